// File: rtl/fifo_pkg.sv
// Shared definitions for the DMA FIFO read/write controllers.
//   AW_DEF        default log2 depth of the storage array
//   ptr_t         pointer type: index plus wrap bit
//   MODE_*        BYTE_MODE encodings
//   byte_lane()   big-endian byte select from a longword
package fifo_pkg;

   localparam int unsigned AW_DEF = 3;
   localparam int unsigned DW     = 32;

   typedef logic [AW_DEF:0] ptr_t;

   localparam logic MODE_LWORD = 1'b0;
   localparam logic MODE_BYTE  = 1'b1;

   localparam logic [1:0] BPTR_LAST = 2'd3;

   // Lane 0 is the most significant byte (big-endian SCSI ordering).
   function automatic logic [7:0] byte_lane(input logic [DW-1:0] word,
                                            input logic [1:0]    bptr);
      logic [7:0] lane;
      lane = 8'h00;
      case (bptr)
         2'd0: lane = word[31:24];
         2'd1: lane = word[23:16];
         2'd2: lane = word[15:8];
         2'd3: lane = word[7:0];
         default: lane = 8'h00;
      endcase
      return lane;
   endfunction

endpackage : fifo_pkg

// File: rtl/fifo_rd_ptr.sv
// AW+1-bit FIFO pointer counter (index plus wrap bit).
//   CLK     system clock
//   RST_    asynchronous active-low reset, clears the pointer
//   inc     advance pointer by one (modulo 2^(AW+1))
//   ld      synchronous load of ld_val, takes priority over inc
//   ld_val  value loaded when ld is high
//   ptr     current pointer
module fifo_rd_ptr
   import fifo_pkg::*;
#(
   parameter int unsigned AW = AW_DEF
) (
   input  logic        CLK,
   input  logic        RST_,
   input  logic        inc,
   input  logic        ld,
   input  logic [AW:0] ld_val,
   output logic [AW:0] ptr
);

   localparam int unsigned PW = AW + 1;

   // Natural binary overflow gives index wrap and wrap-bit toggle together.
   always_ff @(posedge CLK or negedge RST_) begin
      if (!RST_) begin
         ptr <= '0;
      end else if (ld) begin
         ptr <= ld_val;
      end else if (inc) begin
         ptr <= ptr + PW'(1);
      end
   end

endmodule : fifo_rd_ptr

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the 8 x 32 DMA FIFO.
// Owns the read pointer, flags EMPTY/FULL against the write pointer, and
// prefetches one longword into an output register presented over a
// valid/ready handshake, either whole or as four big-endian bytes.
//   CLK, RST_   clock, asynchronous active-low reset
//   WPTR        write pointer from the write side
//   RD_DATA     storage word at RD_ADDR (asynchronous read)
//   BYTE_MODE   1 = byte unpacking, 0 = longword
//   FLUSH       discard all unread data
//   DOUT_READY  consumer accepts DOUT
//   RD_ADDR     storage read index
//   RPTR        read pointer back to the write side
//   EMPTY/FULL  storage occupancy flags
//   DOUT        output data, DOUT_VALID qualifies it
//   LEVEL       unread storage entries (only with FIFO_RD_LEVEL_EN defined)
module fifo_rd_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned AW = AW_DEF
) (
   input  logic          CLK,
   input  logic          RST_,
   input  logic [AW:0]   WPTR,
   input  logic [DW-1:0] RD_DATA,
   input  logic          BYTE_MODE,
   input  logic          FLUSH,
   input  logic          DOUT_READY,
   output logic [AW-1:0] RD_ADDR,
   output logic [AW:0]   RPTR,
   output logic          EMPTY,
   output logic          FULL,
   output logic [DW-1:0] DOUT,
`ifdef FIFO_RD_LEVEL_EN
   output logic [AW:0]   LEVEL,
`endif
   output logic          DOUT_VALID
);

   logic [DW-1:0] oreg;
   logic [1:0]    bptr;
   logic          xfer_c;
   logic          consume_c;
   logic          load_c;

   // Occupancy flags from pointer comparison.
   always_comb begin
      EMPTY = (WPTR == RPTR);
      FULL  = (WPTR[AW-1:0] == RPTR[AW-1:0]) && (WPTR[AW] != RPTR[AW]);
   end

   // Handshake: a word is consumed on its last byte, or at once in longword mode.
   always_comb begin
      xfer_c    = DOUT_VALID & DOUT_READY;
      consume_c = xfer_c;
      if (BYTE_MODE == MODE_BYTE) begin
         consume_c = xfer_c & (bptr == BPTR_LAST);
      end
      load_c    = !EMPTY & (!DOUT_VALID | consume_c);
   end

   fifo_rd_ptr #(
      .AW     (AW)
   ) u_rd_ptr (
      .CLK    (CLK),
      .RST_   (RST_),
      .inc    (load_c),
      .ld     (FLUSH),
      .ld_val (WPTR),
      .ptr    (RPTR)
   );

   assign RD_ADDR = RPTR[AW-1:0];

   // Output stage: refill on the same edge as consume keeps DOUT_VALID high.
   always_ff @(posedge CLK or negedge RST_) begin
      if (!RST_) begin
         oreg       <= '0;
         DOUT_VALID <= 1'b0;
         bptr       <= 2'd0;
      end else if (FLUSH) begin
         DOUT_VALID <= 1'b0;
         bptr       <= 2'd0;
      end else begin
         if (load_c) begin
            oreg       <= RD_DATA;
            DOUT_VALID <= 1'b1;
         end else if (consume_c) begin
            DOUT_VALID <= 1'b0;
         end
         // A longword xfer mid-word drops the remaining bytes.
         if (xfer_c) begin
            if (BYTE_MODE == MODE_BYTE) begin
               bptr <= bptr + 2'd1;
            end else begin
               bptr <= 2'd0;
            end
         end
      end
   end

   // Output mux follows the current mode.
   always_comb begin
      DOUT = oreg;
      if (BYTE_MODE == MODE_BYTE) begin
         DOUT = {24'h0, byte_lane(oreg, bptr)};
      end
   end

`ifdef FIFO_RD_LEVEL_EN
   assign LEVEL = WPTR - RPTR;
`endif

endmodule : fifo_rd_ctrl

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_fifo_rd_ctrl;

   logic        CLK;
   logic        RST_;
   logic [3:0]  WPTR;
   logic [31:0] RD_DATA;
   logic        BYTE_MODE;
   logic        FLUSH;
   logic        DOUT_READY;
   logic [2:0]  RD_ADDR;
   logic [3:0]  RPTR;
   logic        EMPTY;
   logic        FULL;
   logic [31:0] DOUT;
   logic        DOUT_VALID;
`ifdef FIFO_RD_LEVEL_EN
   logic [3:0]  LEVEL;
`endif

   fifo_rd_ctrl #(.AW(3)) dut (
      .CLK        (CLK),
      .RST_       (RST_),
      .WPTR       (WPTR),
      .RD_DATA    (RD_DATA),
      .BYTE_MODE  (BYTE_MODE),
      .FLUSH      (FLUSH),
      .DOUT_READY (DOUT_READY),
      .RD_ADDR    (RD_ADDR),
      .RPTR       (RPTR),
      .EMPTY      (EMPTY),
      .FULL       (FULL),
      .DOUT       (DOUT),
`ifdef FIFO_RD_LEVEL_EN
      .LEVEL      (LEVEL),
`endif
      .DOUT_VALID (DOUT_VALID)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // External storage array, written by the bench acting as write side.
   logic [31:0] mem [8];
   assign RD_DATA = mem[RD_ADDR];

   // Reference model: unread storage as a queue, output stage as word + byte index.
   logic [31:0] q[$];
   bit          have;
   logic [31:0] word;
   int          bidx;
   logic [3:0]  exp_rptr;
   logic [3:0]  wptr;

   int n_chk;
   int n_pass;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      q.delete();
      have     = 0;
      word     = 32'h0;
      bidx     = 0;
      exp_rptr = 4'd0;
      wptr     = 4'd0;
      WPTR     = 4'd0;
   endtask

   task automatic do_write(input logic [31:0] d);
      mem[wptr[2:0]] = d;
      q.push_back(d);
      wptr = wptr + 4'd1;
      WPTR = wptr;
   endtask

   // Advance the model across one rising edge using the inputs now driven.
   task automatic model_edge();
      bit xfer;
      bit consumed;
      if (FLUSH) begin
         q.delete();
         have     = 0;
         bidx     = 0;
         exp_rptr = wptr;
      end else begin
         xfer     = have && DOUT_READY;
         consumed = xfer && (!BYTE_MODE || bidx == 3);
         if (xfer) bidx = BYTE_MODE ? (bidx + 1) % 4 : 0;
         if (consumed) have = 0;
         if (!have && q.size() > 0) begin
            word     = q.pop_front();
            have     = 1;
            exp_rptr = exp_rptr + 4'd1;
         end
      end
   endtask

   task automatic check_all(input string tag);
      logic [31:0] e;
      chk({tag, ".empty"}, 32'(EMPTY), 32'(q.size() == 0));
      chk({tag, ".full"},  32'(FULL),  32'(q.size() == 8));
      chk({tag, ".rptr"},  32'(RPTR),  32'(exp_rptr));
      chk({tag, ".addr"},  32'(RD_ADDR), 32'(exp_rptr[2:0]));
      chk({tag, ".valid"}, 32'(DOUT_VALID), 32'(have));
      if (have) begin
         e = BYTE_MODE ? ((word >> (8 * (3 - bidx))) & 32'h0000_00FF) : word;
         chk({tag, ".dout"}, DOUT, e);
      end
`ifdef FIFO_RD_LEVEL_EN
      chk({tag, ".level"}, 32'(LEVEL), 32'(q.size()));
`endif
   endtask

   // One clock: optional write, drive controls, edge, check at the falling edge.
   task automatic step(input string tag, input bit wr, input logic [31:0] d,
                       input bit bm, input bit fl, input bit rdy);
      if (wr && q.size() < 8) do_write(d);
      BYTE_MODE  = bm;
      FLUSH      = fl;
      DOUT_READY = rdy;
      model_edge();
      @(posedge CLK);
      @(negedge CLK);
      check_all(tag);
   endtask

   initial begin
      n_chk      = 0;
      n_pass     = 0;
      BYTE_MODE  = 1'b0;
      FLUSH      = 1'b0;
      DOUT_READY = 1'b0;
      for (int i = 0; i < 8; i++) mem[i] = 32'h0;
      model_reset();
      RST_ = 1'b0;
      #12;
      check_all("reset");
      @(negedge CLK);
      RST_ = 1'b1;

      // Longword transfer: one-cycle latency, then drains.
      step("lw_load", 1, 32'h1122_3344, 0, 0, 1);
      step("lw_done", 0, 32'h0, 0, 0, 1);

      // Byte unpacking, big-endian order.
      step("by0", 1, 32'h1122_3344, 1, 0, 1);
      chk("by0.byte", DOUT, 32'h11);
      step("by1", 0, 32'h0, 1, 0, 1);
      chk("by1.byte", DOUT, 32'h22);
      step("by2", 0, 32'h0, 1, 0, 1);
      chk("by2.byte", DOUT, 32'h33);
      step("by3", 0, 32'h0, 1, 0, 1);
      chk("by3.byte", DOUT, 32'h44);
      step("by_done", 0, 32'h0, 1, 0, 1);

      // Full and wrap: fill all 8 slots before any edge.
      for (int i = 0; i < 8; i++) do_write(32'hA000_0000 + 32'(i));
      #1;
      chk("full.flag", 32'(FULL), 32'd1);
      check_all("full");
      step("full_load", 0, 32'h0, 0, 0, 0);
      for (int i = 0; i < 9; i++) step("drain", 0, 32'h0, 0, 0, 1);
      chk("drain.empty", 32'(EMPTY), 32'd1);

      // Flush with pending entries and a half-sent word.
      for (int i = 0; i < 4; i++) do_write(32'hC0DE_0000 + 32'(i));
      step("fl_load", 0, 32'h0, 1, 0, 0);
      step("fl_b1", 0, 32'h0, 1, 0, 1);
      step("fl_b2", 0, 32'h0, 1, 0, 1);
      step("flush", 0, 32'h0, 1, 1, 1);
      chk("flush.rptr", 32'(RPTR), 32'(WPTR));
      step("post_fl", 1, 32'hDEAD_BEEF, 1, 0, 0);
      chk("post_fl.msb", DOUT, 32'hDE);

      // Backpressure: output and pointer hold.
      step("bp_fill", 1, 32'h5555_AAAA, 0, 0, 0);
      for (int i = 0; i < 5; i++) step("bp", 0, 32'h0, 0, 0, 0);

      // Mode change mid-word drops the remaining bytes.
      step("mc_b", 1, 32'h0102_0304, 1, 0, 1);
      step("mc_lw", 0, 32'h0, 0, 0, 1);

      // Random traffic, with an asynchronous reset in the middle.
      for (int n = 0; n < 3000; n++) begin
         bit bm_r;
         bm_r = ($urandom_range(0, 15) == 0) ? !BYTE_MODE : BYTE_MODE;
         step("rnd", $urandom_range(0, 1) == 1, $urandom(), bm_r,
              $urandom_range(0, 31) == 0, $urandom_range(0, 9) < 7);
         if (n == 1500) begin
            #2;
            RST_ = 1'b0;
            #1;
            chk("areset.valid", 32'(DOUT_VALID), 32'd0);
            chk("areset.rptr",  32'(RPTR), 32'd0);
            model_reset();
            @(negedge CLK);
            check_all("areset");
            RST_ = 1'b1;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_fifo_rd_ctrl
